// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op/state encodings and request classification helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_SW  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_MERGE_WR,
        ST_RESP
    } lsu_state_e;

    function automatic logic is_store(input lsu_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_unsigned(input lsu_op_e op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b         = word[{lane, 3'b000} +: 8];
        h         = word[{lane[1], 4'b0000} +: 16];
        load_data = word;
        merged    = word;
        case (op)
            OP_LB, OP_LBU: load_data = is_unsigned(op) ? {24'h0, b} : {{24{b[7]}}, b};
            OP_LH, OP_LHU: load_data = is_unsigned(op) ? {16'h0, h} : {{16{h[15]}}, h};
            OP_SB:         merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            OP_SH:         merged[{lane[1], 4'b0000} +: 16] = wdata;
            default:       ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-memory load/store initiator with RMW sub-word stores; LSU_MISALIGN_CHECK_EN enables misalignment errors
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_dout
);

    lsu_state_e  state_q, state_d;
    lsu_op_e     op_q;
    logic [31:0] addr_q, wdata_q, rdata_q, merged_q;
    logic        err_q;
    logic        accept;
    logic        misaligned;
    logic [31:0] lane_load, lane_merged;

    assign accept     = req_valid && req_ready;
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(op_q, addr_q[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_byte_lane u_lane (
        .op        (op_q),
        .lane      (addr_q[1:0]),
        .word      (mem_dout),
        .wdata     (wdata_q[15:0]),
        .load_data (lane_load),
        .merged    (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // mem_we/mem_wd come only from registered state so memory never sees req_* combinationally
    always_comb begin
        state_d = state_q;
        mem_we  = 1'b0;
        mem_wd  = 32'h0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (misaligned) begin
                    state_d = ST_RESP;
                end else if (op_q == OP_SB || op_q == OP_SH) begin
                    state_d = ST_MERGE_WR;
                end else begin
                    if (op_q == OP_SW) begin
                        mem_we = 1'b1;
                        mem_wd = wdata_q;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_MERGE_WR: begin
                mem_we  = 1'b1;
                mem_wd  = merged_q;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_LB;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            merged_q <= 32'h0;
            err_q    <= 1'b0;
        end else if (accept) begin
            op_q    <= lsu_op_e'(req_op);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            if (misaligned)             err_q    <= 1'b1;
            else if (!is_store(op_q))   rdata_q  <= lane_load;
            else                        merged_q <= lane_merged;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench: word memory, cycle-level response/write model, directed vectors
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_dout;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, SW = 3'd3,
                           LBU = 3'd4, LHU = 3'd5, SB = 3'd6, SH = 3'd7;

    always #5 clk = ~clk;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    assign mem_dout = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wd;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'h0, act}, {31'h0, exp});
    endtask

    // Behavioural model: what each accepted request must produce, and on which cycle
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        logic        st;
        logic [31:0] waddr;
        logic [31:0] wword;
    } resp_t;
    typedef struct {
        int          due;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    ready_at = 0;
    int    cyc = 0;
    int    resp_cnt = 0;
    int    we_cnt = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] bt = (w >> (a[1:0] * 8)) & 32'hFF;
        logic [31:0] hw = (w >> (a[1] * 16)) & 32'hFFFF;
        case (op)
            LB:      return (bt >= 32'd128)   ? (bt | 32'hFFFFFF00) : bt;
            LH:      return (hw >= 32'd32768) ? (hw | 32'hFFFF0000) : hw;
            LBU:     return bt;
            LHU:     return hw;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_merge(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] wd);
        int          sh   = (op == SB) ? a[1:0] * 8 : a[1] * 16;
        logic [31:0] mask = (op == SB) ? 32'hFF : 32'hFFFF;
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    function automatic logic model_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        if (op == LH || op == LHU || op == SH) return a[0];
        if (op == LW || op == SW)              return a[1:0] != 2'b00;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_accept();
        resp_t       r;
        wr_t         wr;
        logic [31:0] w     = ref_mem[req_addr[7:2]];
        logic        mis   = model_mis(req_op, req_addr);
        logic        store = (req_op == SW) || (req_op == SB) || (req_op == SH);
        logic        sub   = (req_op == SB) || (req_op == SH);
        r.err   = mis;
        r.data  = (store || mis) ? 32'h0 : exp_load(req_op, req_addr, w);
        r.st    = store && !mis;
        r.waddr = {req_addr[31:2], 2'b00};
        r.wword = 32'h0;
        if (store && !mis) begin
            r.wword = (req_op == SW) ? req_wdata : exp_merge(req_op, req_addr, w, req_wdata);
            wr.due  = cyc + (sub ? 2 : 1);
            wr.addr = r.waddr;
            wr.data = r.wword;
            wr_q.push_back(wr);
        end
        r.due = cyc + ((sub && !mis) ? 3 : 2);
        ready_at = r.due + 1;
        resp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check1("req_ready", req_ready, cyc >= ready_at);
            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                check1("resp_valid", resp_valid, 1'b1);
                check32("resp_rdata", resp_rdata, resp_q[0].data);
                check1("resp_err", resp_err, resp_q[0].err);
                if (resp_q[0].st) ref_mem[resp_q[0].waddr[7:2]] = resp_q[0].wword;
                last_rdata = resp_rdata;
                last_err   = resp_err;
                resp_cnt++;
                void'(resp_q.pop_front());
            end else begin
                check1("resp_valid quiet", resp_valid, 1'b0);
            end
            if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
                check1("mem_we", mem_we, 1'b1);
                check32("mem_addr", mem_addr, wr_q[0].addr);
                check32("mem_wd", mem_wd, wr_q[0].data);
                void'(wr_q.pop_front());
            end else begin
                check1("mem_we quiet", mem_we, 1'b0);
            end
            if (mem_we) we_cnt++;
            if (req_valid && req_ready) model_accept();
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w, input bit hold);
        bit got = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wdata = w;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept timeout: op %0d addr %h not accepted in 20 cycles", op, a);
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_resps(input int target);
        bit got = 0;
        for (int k = 0; k < 60; k++) begin
            if (resp_cnt >= target) begin
                got = 1;
                break;
            end
            @(posedge clk);
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL response timeout: got %0d responses, expected %0d", resp_cnt, target);
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        int c = resp_cnt;
        send(op, a, w, 0);
        wait_resps(c + 1);
    endtask

    int w0;
    int c0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        #2;
        check1("reset req_ready", req_ready, 1'b1);
        check1("reset resp_valid", resp_valid, 1'b0);
        check32("reset resp_rdata", resp_rdata, 32'h0);
        check1("reset resp_err", resp_err, 1'b0);
        check32("reset mem_addr", mem_addr, 32'h0);
        check32("reset mem_wd", mem_wd, 32'h0);
        check1("reset mem_we", mem_we, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // SW then LW at 0x10
        w0 = we_cnt;
        do_op(SW, 32'h10, 32'hDEADBEEF);
        check32("SW write cycles", we_cnt - w0, 32'd1);
        do_op(LW, 32'h10, 32'h0);
        check32("LW 0x10", last_rdata, 32'hDEADBEEF);

        // sub-word loads from 0x80FF7F01
        do_op(SW, 32'h10, 32'h80FF7F01);
        do_op(LB, 32'h11, 32'h0);
        check32("LB 0x11", last_rdata, 32'h0000007F);
        do_op(LB, 32'h12, 32'h0);
        check32("LB 0x12", last_rdata, 32'hFFFFFFFF);
        do_op(LBU, 32'h13, 32'h0);
        check32("LBU 0x13", last_rdata, 32'h00000080);
        do_op(LH, 32'h12, 32'h0);
        check32("LH 0x12", last_rdata, 32'hFFFF80FF);
        do_op(LHU, 32'h12, 32'h0);
        check32("LHU 0x12", last_rdata, 32'h000080FF);

        // read-modify-write stores on 0x11223344
        do_op(SW, 32'h20, 32'h11223344);
        w0 = we_cnt;
        do_op(SB, 32'h21, 32'h000000AB);
        check32("SB write cycles", we_cnt - w0, 32'd1);
        check32("SB 0x21 word", mem[8], 32'h1122AB44);
        do_op(SH, 32'h22, 32'h0000CAFE);
        check32("SH 0x22 word", mem[8], 32'hCAFEAB44);

        // misaligned accesses
        w0 = we_cnt;
`ifdef LSU_MISALIGN_CHECK_EN
        do_op(LW, 32'h22, 32'h0);
        check1("LW 0x22 err", last_err, 1'b1);
        check32("LW 0x22 rdata", last_rdata, 32'h0);
        do_op(SH, 32'h23, 32'h00005555);
        check1("SH 0x23 err", last_err, 1'b1);
        check32("misaligned write cycles", we_cnt - w0, 32'd0);
        check32("misaligned mem unchanged", mem[8], 32'hCAFEAB44);
`else
        do_op(LW, 32'h22, 32'h0);
        check1("LW 0x22 err", last_err, 1'b0);
        check32("LW 0x22 rdata", last_rdata, 32'hCAFEAB44);
        do_op(SH, 32'h23, 32'h00005555);
        check32("SH 0x23 word", mem[8], 32'h5555AB44);
`endif

        // reset during MERGE_WR of an SB
        do_op(SW, 32'h30, 32'h01020304);
        c0 = resp_cnt;
        send(SB, 32'h30, 32'h000000FF, 0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check1("reset mid mem_we", mem_we, 1'b0);
        check1("reset mid resp_valid", resp_valid, 1'b0);
        check1("reset mid req_ready", req_ready, 1'b1);
        resp_q.delete();
        wr_q.delete();
        ready_at = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check32("reset mid mem word", mem[12], 32'h01020304);
        check32("reset mid no response", resp_cnt - c0, 32'd0);

        // req_valid held high across a mix of ops
        c0 = resp_cnt;
        send(SW, 32'h40, 32'hA5A5A5A5, 1);
        send(LBU, 32'h41, 32'h0, 1);
        send(SB, 32'h42, 32'h00000000, 1);
        send(LH, 32'h42, 32'h0, 1);
        send(LW, 32'h40, 32'h0, 0);
        wait_resps(c0 + 5);
        check32("stream final LW", last_rdata, 32'hA500A5A5);

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) check32($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
